// File: rtl/fir_reg_bank.sv
// FIR control register bank with address decode, coefficient-RAM routing,
// validated start pulse, busy lockout, sticky status and interrupt output.
// Everything runs on clk_b with a synchronous active-low reset.
module fir_reg_bank #(
   parameter int ADDR_W   = 6,
   parameter int DATA_W   = 16,
   parameter int RAM_AW   = 5,
   parameter int MAX_WSP  = 32,
   parameter int PROBKI_W = 14
) (
   input  logic                             clk_b,
   input  logic                             rst_n,
   input  logic [ADDR_W-1:0]                CDC_A,
   input  logic [DATA_W-1:0]                CDC_data,
   input  logic                             CDC_wr,
   input  logic                             CDC_rd,
   input  logic [DATA_W-1:0]                ram_rdata,
   output logic [RAM_AW-1:0]                address_RAM,
   output logic                             wr_RAM,
   input  logic                             Pracuje,
   input  logic                             DONE,
   output logic                             Start,
   output logic [$clog2(MAX_WSP+1)-1:0]     Ile_wsp,
   output logic [PROBKI_W-1:0]              Ile_probek,
   output logic                             irq,
   output logic [DATA_W-1:0]                data_back,
   output logic                             rd_valid
);

   localparam int WSP_W  = $clog2(MAX_WSP + 1);
   localparam int N_REGS = 8;

   localparam int IDX_CTRL    = 0;
   localparam int IDX_STATUS  = 1;
   localparam int IDX_IRQ_EN  = 2;
   localparam int IDX_WSP     = 3;
   localparam int IDX_PROBEK  = 4;
   localparam int IDX_SCRATCH = 5;

   // Address decode
   logic              is_reg;
   logic [2:0]        reg_idx;
   logic              rd_req;
   logic [N_REGS-1:0] reg_wr;

   // Architectural state
   logic [WSP_W-1:0]    wsp_reg;
   logic [PROBKI_W-1:0] probek_reg;
   logic [1:0]          irq_en_reg;
   logic [DATA_W-1:0]   scratch_reg;
   logic                done_sticky_reg, done_sticky_next;
   logic                err_sticky_reg, err_sticky_next;
   logic                start_reg;
   logic                irq_reg;

   // Readback pipeline
   logic              rd_valid_reg;
   logic              rd_ram_reg;
   logic [DATA_W-1:0] rd_data_reg;
   logic [DATA_W-1:0] hold_reg;
   logic [DATA_W-1:0] rd_value;
   logic [DATA_W-1:0] data_back_next;

   // Start / error qualification
   logic start_req;
   logic cfg_ok;
   logic start_ok;
   logic err_set;
   logic err_clr;
   logic done_clr;

   assign is_reg  = CDC_A[ADDR_W-1];
   assign reg_idx = CDC_A[2:0];
   // A simultaneous write takes precedence over a read.
   assign rd_req  = CDC_rd & ~CDC_wr;

   // One write-select line per register index.
   genvar gi;
   generate
      for (gi = 0; gi < N_REGS; gi++) begin : g_reg_wr
         assign reg_wr[gi] = CDC_wr & is_reg & (reg_idx == 3'(gi));
      end
   endgenerate

   // Coefficient RAM gets the low address bits directly; upper bits alias.
   assign address_RAM = CDC_A[RAM_AW-1:0];
   assign wr_RAM      = CDC_wr & ~is_reg & ~Pracuje;

   // Start validation and sticky-bit next state, from pre-write register values.
   always_comb begin
      start_req = reg_wr[IDX_CTRL] & CDC_data[0];
      cfg_ok    = ~Pracuje
                  & (wsp_reg != '0)
                  & (wsp_reg <= WSP_W'(MAX_WSP))
                  & (probek_reg != '0);
      start_ok  = start_req & cfg_ok;

      err_set   = (start_req & ~cfg_ok)
                  | (Pracuje & (reg_wr[IDX_WSP] | reg_wr[IDX_PROBEK] | (CDC_wr & ~is_reg)));
      err_clr   = (reg_wr[IDX_CTRL] & CDC_data[1]) | (reg_wr[IDX_STATUS] & CDC_data[2]);
      done_clr  = (reg_wr[IDX_CTRL] & CDC_data[1]) | (reg_wr[IDX_STATUS] & CDC_data[1]);

      // Set beats clear; a fresh run supersedes even a coincident DONE.
      err_sticky_next = err_set | (err_sticky_reg & ~err_clr);
      if (start_ok) begin
         done_sticky_next = 1'b0;
      end else begin
         done_sticky_next = DONE | (done_sticky_reg & ~done_clr);
      end
   end

   // Register-region read mux; RAM-region data is taken from ram_rdata later.
   always_comb begin
      rd_value = '0;
      case (reg_idx)
         3'd1:    rd_value = DATA_W'({err_sticky_reg, done_sticky_reg, Pracuje});
         3'd2:    rd_value = DATA_W'(irq_en_reg);
         3'd3:    rd_value = DATA_W'(wsp_reg);
         3'd4:    rd_value = DATA_W'(probek_reg);
         3'd5:    rd_value = scratch_reg;
         default: rd_value = '0;
      endcase
   end

   // Present fresh read data in the valid cycle, otherwise hold the last value.
   always_comb begin
      data_back_next = hold_reg;
      if (rd_valid_reg) begin
         data_back_next = rd_ram_reg ? ram_rdata : rd_data_reg;
      end
   end

   // Configuration registers; counts are locked while the core is busy.
   always_ff @(posedge clk_b) begin
      if (!rst_n) begin
         wsp_reg     <= '0;
         probek_reg  <= '0;
         irq_en_reg  <= '0;
         scratch_reg <= '0;
      end else begin
         if (reg_wr[IDX_WSP] && !Pracuje)    wsp_reg     <= CDC_data[WSP_W-1:0];
         if (reg_wr[IDX_PROBEK] && !Pracuje) probek_reg  <= CDC_data[PROBKI_W-1:0];
         if (reg_wr[IDX_IRQ_EN])             irq_en_reg  <= CDC_data[1:0];
         if (reg_wr[IDX_SCRATCH])            scratch_reg <= CDC_data;
      end
   end

   // Sticky status, start pulse and interrupt (irq lags the sticky bits by a cycle).
   always_ff @(posedge clk_b) begin
      if (!rst_n) begin
         done_sticky_reg <= 1'b0;
         err_sticky_reg  <= 1'b0;
         start_reg       <= 1'b0;
         irq_reg         <= 1'b0;
      end else begin
         done_sticky_reg <= done_sticky_next;
         err_sticky_reg  <= err_sticky_next;
         start_reg       <= start_ok;
         irq_reg         <= (done_sticky_reg & irq_en_reg[0]) | (err_sticky_reg & irq_en_reg[1]);
      end
   end

   // Readback pipeline: capture region and register value on the read cycle.
   always_ff @(posedge clk_b) begin
      if (!rst_n) begin
         rd_valid_reg <= 1'b0;
         rd_ram_reg   <= 1'b0;
         rd_data_reg  <= '0;
         hold_reg     <= '0;
      end else begin
         rd_valid_reg <= rd_req;
         if (rd_req) begin
            rd_ram_reg  <= ~is_reg;
            rd_data_reg <= rd_value;
         end
         if (rd_valid_reg) begin
            hold_reg <= data_back_next;
         end
      end
   end

   assign Start      = start_reg;
   assign Ile_wsp    = wsp_reg;
   assign Ile_probek = probek_reg;
   assign irq        = irq_reg;
   assign rd_valid   = rd_valid_reg;
   assign data_back  = data_back_next;

endmodule

// File: tb/tb_fir_reg_bank.sv
// Self-checking bench for fir_reg_bank: directed scenarios followed by
// randomized traffic compared against a behavioural register-map model.
module tb_fir_reg_bank;

   logic        clk_b = 1'b0;
   logic        rst_n;
   logic [5:0]  CDC_A;
   logic [15:0] CDC_data;
   logic        CDC_wr;
   logic        CDC_rd;
   logic [15:0] ram_rdata;
   logic [4:0]  address_RAM;
   logic        wr_RAM;
   logic        Pracuje;
   logic        DONE;
   logic        Start;
   logic [5:0]  Ile_wsp;
   logic [13:0] Ile_probek;
   logic        irq;
   logic [15:0] data_back;
   logic        rd_valid;

   int checks = 0;
   int passed = 0;

   fir_reg_bank #(
      .ADDR_W(6), .DATA_W(16), .RAM_AW(5), .MAX_WSP(32), .PROBKI_W(14)
   ) dut (
      .clk_b(clk_b), .rst_n(rst_n), .CDC_A(CDC_A), .CDC_data(CDC_data),
      .CDC_wr(CDC_wr), .CDC_rd(CDC_rd), .ram_rdata(ram_rdata),
      .address_RAM(address_RAM), .wr_RAM(wr_RAM), .Pracuje(Pracuje),
      .DONE(DONE), .Start(Start), .Ile_wsp(Ile_wsp), .Ile_probek(Ile_probek),
      .irq(irq), .data_back(data_back), .rd_valid(rd_valid)
   );

   always #5 clk_b = ~clk_b;

   // Synchronous coefficient RAM attached to the DUT's RAM port.
   logic        ram_init;
   logic [15:0] ram_mem [32];
   always @(posedge clk_b) begin
      if (ram_init) begin
         for (int i = 0; i < 32; i++) ram_mem[i] <= '0;
         ram_rdata <= '0;
      end else begin
         if (wr_RAM) ram_mem[address_RAM] <= CDC_data;
         ram_rdata <= ram_mem[address_RAM];
      end
   end

   // Behavioural model state
   logic [5:0]  m_wsp;
   logic [13:0] m_probek;
   logic [1:0]  m_en;
   logic [15:0] m_scratch;
   logic        m_done, m_err;
   logic [15:0] m_ram [32];
   logic        exp_start, exp_rdv, exp_irq, exp_wr_ram;
   logic [15:0] exp_db;
   logic        obs_wr_ram;
   logic [4:0]  obs_addr_ram;

   function automatic logic [15:0] model_reg(input logic [2:0] idx, input logic pr);
      case (idx)
         3'd1:    return {13'd0, m_err, m_done, pr};
         3'd2:    return {14'd0, m_en};
         3'd3:    return {10'd0, m_wsp};
         3'd4:    return {2'd0, m_probek};
         3'd5:    return m_scratch;
         default: return 16'd0;
      endcase
   endfunction

   // Drive one cycle, advance the model, then sample just after the edge.
   task automatic drive(input logic wr, input logic rd, input logic [5:0] a,
                        input logic [15:0] d, input logic pr, input logic dn,
                        input logic rs);
      logic st_req, st_ok, set_err, clr_err, clr_done;
      CDC_wr = wr; CDC_rd = rd; CDC_A = a; CDC_data = d;
      Pracuje = pr; DONE = dn; rst_n = rs;
      #1;
      obs_wr_ram   = wr_RAM;
      obs_addr_ram = address_RAM;
      exp_wr_ram   = wr && !a[5] && !pr;
      if (!rs) begin
         m_wsp = 0; m_probek = 0; m_en = 0; m_scratch = 0;
         m_done = 0; m_err = 0;
         exp_start = 0; exp_rdv = 0; exp_irq = 0; exp_db = 0;
      end else begin
         exp_irq = (m_done && m_en[0]) || (m_err && m_en[1]);
         exp_rdv = rd && !wr;
         if (exp_rdv) exp_db = a[5] ? model_reg(a[2:0], pr) : m_ram[a[4:0]];
         st_req = 0; st_ok = 0; set_err = 0; clr_err = 0; clr_done = 0;
         if (wr && a[5]) begin
            case (a[2:0])
               3'd0: begin
                  st_req = d[0];
                  if (d[0]) begin
                     if (!pr && m_wsp >= 1 && m_wsp <= 32 && m_probek != 0) st_ok = 1;
                     else set_err = 1;
                  end
                  if (d[1]) begin clr_done = 1; clr_err = 1; end
               end
               3'd1: begin clr_done = d[1]; clr_err = d[2]; end
               3'd2: m_en = d[1:0];
               3'd3: if (pr) set_err = 1; else m_wsp = d[5:0];
               3'd4: if (pr) set_err = 1; else m_probek = d[13:0];
               3'd5: m_scratch = d;
               default: ;
            endcase
         end else if (wr) begin
            if (pr) set_err = 1;
            else m_ram[a[4:0]] = d;
         end
         exp_start = st_ok;
         if (st_ok) m_done = 0;
         else if (dn) m_done = 1;
         else if (clr_done) m_done = 0;
         if (set_err) m_err = 1;
         else if (clr_err) m_err = 0;
      end
      @(posedge clk_b);
      #1;
   endtask

   task automatic idle();
      drive(0, 0, 6'h00, 16'h0000, 0, 0, 1);
   endtask

   task automatic test_reset();
      drive(0, 0, 6'h00, 16'h0000, 0, 0, 0);
      drive(0, 0, 6'h00, 16'h0000, 0, 0, 0);
      ram_init = 0;
      checks++; if (Start !== 1'b0) $display("FAIL reset_start: got %b want 0", Start); else passed++;
      checks++; if (irq !== 1'b0) $display("FAIL reset_irq: got %b want 0", irq); else passed++;
      checks++; if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid: got %b want 0", rd_valid); else passed++;
      checks++; if (data_back !== 16'h0) $display("FAIL reset_data_back: got %h want 0", data_back); else passed++;
      checks++; if (Ile_wsp !== 6'd0) $display("FAIL reset_wsp: got %0d want 0", Ile_wsp); else passed++;
      checks++; if (Ile_probek !== 14'd0) $display("FAIL reset_probek: got %0d want 0", Ile_probek); else passed++;
      for (int i = 0; i < 8; i++) begin
         drive(0, 1, {3'b100, 3'(i)}, 16'h0000, 0, 0, 1);
         checks++; if (rd_valid !== 1'b1) $display("FAIL reset_read_valid[%0d]: got %b want 1", i, rd_valid); else passed++;
         checks++; if (data_back !== 16'h0) $display("FAIL reset_read_data[%0d]: got %h want 0", i, data_back); else passed++;
         checks++; if (Start !== 1'b0) $display("FAIL reset_read_start[%0d]: got %b want 0", i, Start); else passed++;
      end
      $display("test_reset done");
   endtask

   task automatic test_start();
      drive(1, 0, 6'h23, 16'd5, 0, 0, 1);
      checks++; if (Ile_wsp !== 6'd5) $display("FAIL start_wsp_out: got %0d want 5", Ile_wsp); else passed++;
      drive(1, 0, 6'h24, 16'd10, 0, 0, 1);
      drive(1, 0, 6'h20, 16'h0001, 0, 0, 1);
      checks++; if (Start !== 1'b1) $display("FAIL start_pulse: got %b want 1", Start); else passed++;
      idle();
      checks++; if (Start !== 1'b0) $display("FAIL start_one_cycle: got %b want 0", Start); else passed++;
      drive(0, 1, 6'h21, 16'h0, 0, 0, 1);
      checks++; if (data_back !== 16'h0) $display("FAIL start_status: got %h want 0", data_back); else passed++;
      drive(0, 1, 6'h23, 16'h0, 0, 0, 1);
      checks++; if (data_back !== 16'd5) $display("FAIL start_read_wsp: got %h want 5", data_back); else passed++;
      drive(0, 1, 6'h24, 16'h0, 0, 0, 1);
      checks++; if (data_back !== 16'd10) $display("FAIL start_read_probek: got %h want a", data_back); else passed++;
      $display("test_start done");
   endtask

   task automatic test_bad_start();
      drive(1, 0, 6'h23, 16'd33, 0, 0, 1);
      drive(1, 0, 6'h20, 16'h0001, 0, 0, 1);
      checks++; if (Start !== 1'b0) $display("FAIL bad_start_pulse: got %b want 0", Start); else passed++;
      drive(0, 1, 6'h21, 16'h0, 0, 0, 1);
      checks++; if (data_back !== 16'h4) $display("FAIL bad_start_status: got %h want 4", data_back); else passed++;
      drive(1, 0, 6'h21, 16'h0004, 0, 0, 1);
      drive(0, 1, 6'h21, 16'h0, 0, 0, 1);
      checks++; if (data_back !== 16'h0) $display("FAIL bad_start_w1c: got %h want 0", data_back); else passed++;
      $display("test_bad_start done");
   endtask

   task automatic test_busy();
      drive(1, 0, 6'h03, 16'hABCD, 1, 0, 1);
      checks++; if (obs_wr_ram !== 1'b0) $display("FAIL busy_wr_ram: got %b want 0", obs_wr_ram); else passed++;
      drive(1, 0, 6'h23, 16'd7, 1, 0, 1);
      checks++; if (Ile_wsp !== 6'd33) $display("FAIL busy_wsp_locked: got %0d want 33", Ile_wsp); else passed++;
      drive(0, 1, 6'h21, 16'h0, 0, 0, 1);
      checks++; if (data_back !== 16'h4) $display("FAIL busy_err: got %h want 4", data_back); else passed++;
      drive(1, 0, 6'h03, 16'h1234, 0, 0, 1);
      checks++; if (obs_wr_ram !== 1'b1) $display("FAIL idle_wr_ram: got %b want 1", obs_wr_ram); else passed++;
      checks++; if (obs_addr_ram !== 5'd3) $display("FAIL idle_addr_ram: got %0d want 3", obs_addr_ram); else passed++;
      drive(0, 1, 6'h03, 16'h0, 0, 0, 1);
      checks++; if (rd_valid !== 1'b1) $display("FAIL ram_read_valid: got %b want 1", rd_valid); else passed++;
      checks++; if (data_back !== 16'h1234) $display("FAIL ram_read_data: got %h want 1234", data_back); else passed++;
      idle();
      checks++; if (data_back !== 16'h1234) $display("FAIL ram_read_hold: got %h want 1234", data_back); else passed++;
      $display("test_busy done");
   endtask

   task automatic test_irq();
      drive(1, 0, 6'h20, 16'h0002, 0, 0, 1);
      drive(1, 0, 6'h22, 16'h0001, 0, 0, 1);
      idle();
      checks++; if (irq !== 1'b0) $display("FAIL irq_quiet: got %b want 0", irq); else passed++;
      drive(0, 0, 6'h00, 16'h0, 0, 1, 1);
      checks++; if (irq !== 1'b0) $display("FAIL irq_lag: got %b want 0", irq); else passed++;
      idle();
      checks++; if (irq !== 1'b1) $display("FAIL irq_done: got %b want 1", irq); else passed++;
      drive(1, 0, 6'h21, 16'h0002, 0, 1, 1);
      drive(0, 1, 6'h21, 16'h0, 0, 0, 1);
      checks++; if (data_back !== 16'h2) $display("FAIL irq_set_wins: got %h want 2", data_back); else passed++;
      drive(1, 0, 6'h21, 16'h0002, 0, 0, 1);
      drive(0, 1, 6'h21, 16'h0, 0, 0, 1);
      checks++; if (data_back !== 16'h0) $display("FAIL irq_w1c_done: got %h want 0", data_back); else passed++;
      checks++; if (irq !== 1'b0) $display("FAIL irq_cleared: got %b want 0", irq); else passed++;
      $display("test_irq done");
   endtask

   task automatic test_back_to_back();
      drive(1, 0, 6'h25, 16'hBEEF, 0, 0, 1);
      drive(0, 1, 6'h25, 16'h0, 0, 0, 1);
      checks++; if (data_back !== 16'hBEEF) $display("FAIL b2b_scratch: got %h want beef", data_back); else passed++;
      drive(0, 1, 6'h22, 16'h0, 0, 0, 1);
      checks++; if (data_back !== 16'h1) $display("FAIL b2b_irq_en: got %h want 1", data_back); else passed++;
      drive(0, 1, 6'h26, 16'h0, 0, 0, 1);
      checks++; if (data_back !== 16'h0) $display("FAIL b2b_reserved: got %h want 0", data_back); else passed++;
      drive(0, 1, 6'h03, 16'h0, 0, 0, 1);
      checks++; if (data_back !== 16'h1234) $display("FAIL b2b_ram: got %h want 1234", data_back); else passed++;
      checks++; if (rd_valid !== 1'b1) $display("FAIL b2b_valid: got %b want 1", rd_valid); else passed++;
      $display("test_back_to_back done");
   endtask

   task automatic test_reset_start();
      drive(1, 0, 6'h23, 16'd5, 0, 0, 1);
      drive(1, 0, 6'h20, 16'h0001, 0, 0, 0);
      checks++; if (Start !== 1'b0) $display("FAIL rst_start_pulse: got %b want 0", Start); else passed++;
      checks++; if (Ile_wsp !== 6'd0) $display("FAIL rst_start_wsp: got %0d want 0", Ile_wsp); else passed++;
      idle();
      checks++; if (Start !== 1'b0) $display("FAIL rst_start_after: got %b want 0", Start); else passed++;
      $display("test_reset_start done");
   endtask

   task automatic test_random();
      logic [5:0]  a;
      logic [15:0] d;
      logic        wr, rd, pr, dn;
      for (int n = 0; n < 600; n++) begin
         a  = ($urandom_range(0, 2) != 0) ? {1'b1, 2'($urandom), 3'($urandom)} : 6'($urandom_range(0, 31));
         d  = ($urandom_range(0, 2) != 0) ? 16'($urandom_range(0, 40)) : 16'($urandom);
         wr = ($urandom_range(0, 1) == 0);
         rd = ($urandom_range(0, 1) == 0);
         pr = ($urandom_range(0, 5) == 0);
         dn = ($urandom_range(0, 7) == 0);
         drive(wr, rd, a, d, pr, dn, 1);
         checks++; if (obs_wr_ram !== exp_wr_ram) $display("FAIL rnd_wr_ram[%0d]: got %b want %b", n, obs_wr_ram, exp_wr_ram); else passed++;
         checks++; if (obs_addr_ram !== a[4:0]) $display("FAIL rnd_addr_ram[%0d]: got %0d want %0d", n, obs_addr_ram, a[4:0]); else passed++;
         checks++; if (Start !== exp_start) $display("FAIL rnd_start[%0d]: got %b want %b", n, Start, exp_start); else passed++;
         checks++; if (rd_valid !== exp_rdv) $display("FAIL rnd_rd_valid[%0d]: got %b want %b", n, rd_valid, exp_rdv); else passed++;
         checks++; if (data_back !== exp_db) $display("FAIL rnd_data_back[%0d]: got %h want %h", n, data_back, exp_db); else passed++;
         checks++; if (irq !== exp_irq) $display("FAIL rnd_irq[%0d]: got %b want %b", n, irq, exp_irq); else passed++;
         checks++; if (Ile_wsp !== m_wsp) $display("FAIL rnd_wsp[%0d]: got %0d want %0d", n, Ile_wsp, m_wsp); else passed++;
         checks++; if (Ile_probek !== m_probek) $display("FAIL rnd_probek[%0d]: got %0d want %0d", n, Ile_probek, m_probek); else passed++;
      end
      $display("test_random done: 600 cycles");
   endtask

   initial begin
      ram_init = 1;
      for (int i = 0; i < 32; i++) m_ram[i] = '0;
      rst_n = 0; CDC_A = 0; CDC_data = 0; CDC_wr = 0; CDC_rd = 0;
      Pracuje = 0; DONE = 0;
      @(posedge clk_b);
      #1;
      test_reset();
      test_start();
      test_bad_start();
      test_busy();
      test_irq();
      test_back_to_back();
      test_reset_start();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/fir_reg_bank.md
# fir_reg_bank

Parametrised successor to the fixed FIR control-register file and its address decoder, merged into one synchronous block in the `clk_b` domain. It sits between the CDC module output (`CDC_A`/`CDC_data`/`CDC_wr`/`CDC_rd`) and the FIR core. It also:
- routes coefficient-RAM accesses;
- registers readback with a valid strobe;
- generates a validated one-cycle `Start` pulse;
- locks configuration while the core is busy;
- keeps sticky DONE/error status with an interrupt output.

## Interface
Parameters:
- `ADDR_W`, 6, CDC address width; MSB selects register region (1) or coefficient RAM (0).
- `DATA_W`, 16, data width.
- `RAM_AW`, 5, coefficient RAM address width (`RAM_AW <= ADDR_W-1`).
- `MAX_WSP`, 32, maximum legal coefficient count.
- `PROBKI_W`, 14, sample-count width.

Ports:
- `clk_b`  in  1  single clock; one clock, all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `CDC_A`  in  `ADDR_W`  access address.
- `CDC_data`  in  `DATA_W`  write data (also fed directly to RAM data input).
- `CDC_wr`  in  1  write strobe, one access per cycle.
- `CDC_rd`  in  1  read strobe; ignored when `CDC_wr`=1 in same cycle.
- `ram_rdata`  in  `DATA_W`  synchronous RAM output (valid one cycle after address).
- `address_RAM`  out  `RAM_AW`  `CDC_A[RAM_AW-1:0]`, combinational.
- `wr_RAM`  out  1  gated RAM write enable, combinational.
- `Pracuje`  in  1  FIR core busy level.
- `DONE`  in  1  FIR core completion pulse.
- `Start`  out  1  one-cycle start pulse.
- `Ile_wsp`  out  `$clog2(MAX_WSP+1)`  coefficient count.
- `Ile_probek`  out  `PROBKI_W`  sample count.
- `irq`  out  1  `done_sticky & irq_en[0] | err_sticky & irq_en[1]`, registered.
- `data_back`  out  `DATA_W`  registered read data.
- `rd_valid`  out  1  `data_back` valid strobe.

## Operation
Register region (`CDC_A[ADDR_W-1]`=1, index `CDC_A[2:0]`):
- 0 CTRL
  - Write bit0=1 requests start.
  - Write bit1=1 clears `done_sticky` and `err_sticky`.
  - Reads 0.
- 1 STATUS (read-only)
  - {…0, err_sticky, done_sticky, Pracuje}.
  - Write of bit1/bit2 = 1 clears the respective sticky bit (W1C).
- 2 IRQ_EN: 2 bits, R/W.
- 3 ILE_WSP: R/W, stored truncated to port width.
- 4 ILE_PROBEK: R/W, truncated to `PROBKI_W`.
- 5 SCRATCH: `DATA_W`, R/W.
- 6, 7: reserved; writes ignored, reads 0.

RAM region (`CDC_A[ADDR_W-1]`=0):
- `wr_RAM = CDC_wr & ~Pracuje`.
- Address bits above `RAM_AW` are ignored (aliasing).

Start validation, on a CTRL write with bit0=1:
- `Start`=1 the next cycle only if all of the following hold:
  - `Pracuje`=0;
  - 1 ≤ `Ile_wsp` ≤ `MAX_WSP`;
  - `Ile_probek` ≠ 0.
- Otherwise `Start` stays 0 and `err_sticky` is set.
- A successful start clears `done_sticky`.

Busy lockout:
- While `Pracuje`=1, writes to ILE_WSP, ILE_PROBEK or the RAM region are dropped and set `err_sticky`.
- IRQ_EN, SCRATCH and STATUS W1C remain writable.

Sticky bits:
- `DONE`=1 sets `done_sticky`.
- If a set and a clear occur in the same cycle, set wins.

Readback:
- `CDC_rd` captures region and index.
- Next cycle: `rd_valid`=1 and `data_back` = register value, or `ram_rdata` for the RAM region.
- Back-to-back reads are allowed, one per cycle.

## Timing
- Reset (`rst_n`=0 at an edge): all registers 0. This gives:
  - `Start`=0, `irq`=0, `rd_valid`=0, `data_back`=0;
  - `Ile_wsp`=0, `Ile_probek`=0;
  - sticky bits 0, pipeline cleared.
- Reset mid-operation aborts any pending `Start`/readback; nothing is emitted after reset deasserts.
- Write latency: register updated at the edge of the `CDC_wr` cycle; the new value is visible on outputs the next cycle.
- `Start`: asserted exactly one cycle, in the cycle after the CTRL write edge.
  - Validation uses register values before that write cycle.
  - `Pracuje` is sampled in the write cycle.
- Readback latency is exactly 1 cycle from `CDC_rd`. `data_back` holds its last value when `rd_valid`=0.
- `irq` is updated one cycle after the sticky-bit change.
- `DONE` and a CTRL start in the same cycle with `Pracuje`=0: `done_sticky` ends cleared (start clear wins over DONE set, since the new run supersedes).

## Test plan
- Reset, then read indices 0..7 → `rd_valid` 1 cycle after each read, all `data_back`=0, `Start`=0, `irq`=0.
- Write ILE_WSP=5, ILE_PROBEK=10, CTRL=1 → one-cycle `Start`, `err_sticky`=0. Read back 5 and 10.
- Write ILE_WSP=33 (MAX_WSP=32), CTRL=1 → no `Start`, STATUS reads 0x4. Write STATUS=0x4 → STATUS reads 0.
- `Pracuje`=1; write RAM addr 3 = 0xABCD and ILE_WSP=7 → `wr_RAM`=0, ILE_WSP unchanged, `err_sticky`=1.
  - Then `Pracuje`=0; write RAM addr 3 = 0x1234 → `wr_RAM`=1, `address_RAM`=3.
  - Read addr 3 with `ram_rdata`=0x1234 → `data_back`=0x1234 one cycle later.
- IRQ_EN=1; pulse `DONE` → `done_sticky`=1, `irq`=1 next cycle.
  - DONE pulse coincident with a W1C of bit1 → `done_sticky` stays 1.
- Issue CTRL=1 with valid config, assert `rst_n`=0 in the same cycle → `Start` never asserts, `Ile_wsp`=0 after reset.
